wb_axis_fifo_bridge: RTL and testbench

Wishbone-slave to AXI-Stream bridge with independent TX and RX FIFOs, a status register and TLAST framing. It sits between the user-project Wishbone decode and a stream accelerator (e.g. FIR) and supersedes the unbuffered single-word bridge. The CPU can post up to pDEPTH samples ahead and drain results later. Every access completes with a registered one-cycle ack, and unmapped offsets never hang the bus.

---
 rtl/wb_axis_fifo_bridge_if.sv | 44 ++++
 rtl/wb_axis_fifo_bridge.sv | 151 +++++++++++++++
 tb/tb_wb_axis_fifo_bridge.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_axis_fifo_bridge_if.sv
// Bus bundle for the Wishbone-to-AXI-Stream FIFO bridge: the Wishbone slave
// port, the TX stream (bridge to accelerator) and the RX stream
// (accelerator to bridge).
interface wb_axis_fifo_bridge_if #(
  parameter int pDATA_WIDTH = 32
);
  // Wishbone side
  logic [31:0]            wbs_adr_i;
  logic                   wb_valid;
  logic                   wb_ready;
  logic                   wbs_we_i;
  logic [pDATA_WIDTH-1:0] wbs_dat_i;
  logic [pDATA_WIDTH-1:0] wbs_dat_o;
  // TX stream
  logic                   sm_tvalid;
  logic                   sm_tready;
  logic [pDATA_WIDTH-1:0] sm_tdata;
  logic                   sm_tlast;
  // RX stream
  logic                   ss_tvalid;
  logic                   ss_tready;
  logic [pDATA_WIDTH-1:0] ss_tdata;
  logic                   ss_tlast;

  // The bridge itself
  modport slave (
    input  wbs_adr_i, wb_valid, wbs_we_i, wbs_dat_i,
    output wb_ready, wbs_dat_o,
    output sm_tvalid, sm_tdata, sm_tlast,
    input  sm_tready,
    input  ss_tvalid, ss_tdata, ss_tlast,
    output ss_tready
  );

  // The CPU / accelerator side that talks to the bridge
  modport master (
    output wbs_adr_i, wb_valid, wbs_we_i, wbs_dat_i,
    input  wb_ready, wbs_dat_o,
    input  sm_tvalid, sm_tdata, sm_tlast,
    output sm_tready,
    output ss_tvalid, ss_tdata, ss_tlast,
    input  ss_tready
  );
endinterface

// File: rtl/wb_axis_fifo_bridge.sv
// Wishbone slave to AXI-Stream bridge with a TX FIFO (CPU writes, stream
// reads), an RX FIFO (stream writes, CPU reads), a status register and TLAST
// framing. Every bus access completes with a registered one-cycle ack; an
// access that cannot complete yet (TX full / RX empty) waits in IDLE.
module wb_axis_fifo_bridge #(
  parameter int          pDATA_WIDTH = 32,
  parameter logic [31:0] pADDR_BASE  = 32'h3000_0080,
  parameter int          pDEPTH      = 4
) (
  input logic                    clk,
  input logic                    rst,
  wb_axis_fifo_bridge_if.slave   bus
);

  localparam int AW = $clog2(pDEPTH);
  localparam int CW = AW + 1;
  localparam int EW = pDATA_WIDTH + 1;   // {tlast, data}

  typedef enum logic {S_IDLE, S_ACK} state_e;
  typedef logic [EW-1:0] entry_t;

  state_e                 state_q, state_d;
  logic [pDATA_WIDTH-1:0] rdata_q, rdata_d;
  entry_t                 tx_mem_q [pDEPTH];
  entry_t                 tx_mem_d [pDEPTH];
  entry_t                 rx_mem_q [pDEPTH];
  entry_t                 rx_mem_d [pDEPTH];
  logic [AW-1:0]          tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [AW-1:0]          rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [CW-1:0]          tx_count_q, tx_count_d, rx_count_q, rx_count_d;

  logic hit_tx, hit_rx, hit_st, hit_txl;
  logic tx_full, rx_empty, stall, accept;
  logic bus_push, bus_pop, tx_pop, rx_push, rx_ready;
  entry_t                 rx_head;
  logic [pDATA_WIDTH-1:0] status;

  // Register decode on the full byte address; anything else is unmapped
  assign hit_tx  = bus.wbs_adr_i == pADDR_BASE;
  assign hit_rx  = bus.wbs_adr_i == pADDR_BASE + 32'h4;
  assign hit_st  = bus.wbs_adr_i == pADDR_BASE + 32'h8;
  assign hit_txl = bus.wbs_adr_i == pADDR_BASE + 32'hC;

  // Fullness comes from the registered counts only, so a same-cycle stream
  // pop never makes room for a bus push (and vice versa on RX)
  assign tx_full  = tx_count_q == CW'(pDEPTH);
  assign rx_empty = rx_count_q == '0;
  assign rx_head  = rx_mem_q[rx_rd_q];

  assign stall    = ( bus.wbs_we_i && (hit_tx || hit_txl) && tx_full) ||
                    (!bus.wbs_we_i && hit_rx && rx_empty);
  assign accept   = (state_q == S_IDLE) && bus.wb_valid && !stall;
  assign bus_push = accept &&  bus.wbs_we_i && (hit_tx || hit_txl);
  assign bus_pop  = accept && !bus.wbs_we_i && hit_rx;

  assign tx_pop   = (tx_count_q != '0) && bus.sm_tready;
  assign rx_ready = !rst && (rx_count_q != CW'(pDEPTH));
  assign rx_push  = bus.ss_tvalid && rx_ready;

  // Status word assembled from registered FIFO state
  always_comb begin
    status        = '0;
    status[0]     = tx_full;
    status[1]     = rx_empty;
    status[2]     = !rx_empty && rx_head[pDATA_WIDTH];
    status[15:8]  = 8'(tx_count_q);
    status[23:16] = 8'(rx_count_q);
  end

  // Bus FSM next state plus FIFO pointer, count and storage updates
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    state_d    = state_q;
    rdata_d    = '0;
    tx_mem_d   = tx_mem_q;
    rx_mem_d   = rx_mem_q;
    tx_wr_d    = tx_wr_q;
    tx_rd_d    = tx_rd_q;
    rx_wr_d    = rx_wr_q;
    rx_rd_d    = rx_rd_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_ACK;
          if (!bus.wbs_we_i) begin
            if (hit_rx)      rdata_d = rx_head[pDATA_WIDTH-1:0];
            else if (hit_st) rdata_d = status;
          end
        end
      end
      // Ack is a one-cycle pulse; the still-asserted request is not replayed
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (bus_push) begin
      tx_mem_d[tx_wr_q] = {hit_txl, bus.wbs_dat_i};
      tx_wr_d           = tx_wr_q + AW'(1);
    end
    if (tx_pop)  tx_rd_d = tx_rd_q + AW'(1);
    tx_count_d = tx_count_q + CW'(bus_push) - CW'(tx_pop);

    if (rx_push) begin
      rx_mem_d[rx_wr_q] = {bus.ss_tlast, bus.ss_tdata};
      rx_wr_d           = rx_wr_q + AW'(1);
    end
    if (bus_pop) rx_rd_d = rx_rd_q + AW'(1);
    rx_count_d = rx_count_q + CW'(rx_push) - CW'(bus_pop);
  end

  // State register with synchronous reset; storage is cleared so the idle
  // stream data reads as zero after reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state_q    <= S_IDLE;
      rdata_q    <= '0;
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      tx_count_q <= '0;
      rx_count_q <= '0;
      // NOTE: the FIFO arrays are reset on purpose (small, and sm_tdata must read 0).
      for (int i = 0; i < pDEPTH; i++) begin
        tx_mem_q[i] <= '0;
        rx_mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      rdata_q    <= rdata_d;
      tx_wr_q    <= tx_wr_d;
      tx_rd_q    <= tx_rd_d;
      rx_wr_q    <= rx_wr_d;
      rx_rd_q    <= rx_rd_d;
      tx_count_q <= tx_count_d;
      rx_count_q <= rx_count_d;
      tx_mem_q   <= tx_mem_d;
      rx_mem_q   <= rx_mem_d;
    end
  end

  assign bus.wb_ready  = state_q == S_ACK;
  assign bus.wbs_dat_o = rdata_q;
  assign bus.sm_tvalid = tx_count_q != '0;
  assign bus.sm_tdata  = tx_mem_q[tx_rd_q][pDATA_WIDTH-1:0];
  assign bus.sm_tlast  = tx_mem_q[tx_rd_q][pDATA_WIDTH];
  assign bus.ss_tready = rx_ready;

endmodule

// File: tb/tb_wb_axis_fifo_bridge.sv
// Self-checking bench for wb_axis_fifo_bridge: a queue-based reference model
// compared against the DUT every cycle, plus directed literal checks.
module tb_wb_axis_fifo_bridge;

  localparam int          DW    = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h3000_0080;
  localparam logic [31:0] A_TX  = BASE;
  localparam logic [31:0] A_RX  = BASE + 32'h4;
  localparam logic [31:0] A_ST  = BASE + 32'h8;
  localparam logic [31:0] A_TXL = BASE + 32'hC;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  wb_axis_fifo_bridge_if #(.pDATA_WIDTH(DW)) bus ();

  wb_axis_fifo_bridge #(
    .pDATA_WIDTH(DW),
    .pADDR_BASE (BASE),
    .pDEPTH     (DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  beat_t         m_tx[$];
  beat_t         m_rx[$];
  beat_t         sent[$];
  logic          m_ack   = 1'b0;
  logic [DW-1:0] m_rdata = '0;
  bit            model_on = 1'b0;

  function automatic logic [DW-1:0] m_status();
    logic [DW-1:0] s;
    s        = '0;
    s[0]     = m_tx.size() == DEPTH;
    s[1]     = m_rx.size() == 0;
    if (m_rx.size() != 0) s[2] = m_rx[0].last;
    s[15:8]  = 8'(m_tx.size());
    s[23:16] = 8'(m_rx.size());
    return s;
  endfunction

  always @(posedge clk) begin : model_p
    int    tx_n;
    int    rx_n;
    bit    do_tx_pop;
    bit    do_rx_push;
    bit    push_tx;
    bit    pop_rx;
    beat_t nb;
    logic [31:0] a;
    if (rst) begin
      m_tx.delete();
      m_rx.delete();
      m_ack   = 1'b0;
      m_rdata = '0;
    end else begin
      tx_n       = m_tx.size();
      rx_n       = m_rx.size();
      do_tx_pop  = (tx_n != 0) && bus.sm_tready;
      do_rx_push = bus.ss_tvalid && (rx_n != DEPTH);
      push_tx    = 1'b0;
      pop_rx     = 1'b0;
      nb         = '0;
      a          = bus.wbs_adr_i;
      if (m_ack) begin
        m_ack   = 1'b0;
        m_rdata = '0;
      end else if (bus.wb_valid) begin
        if (bus.wbs_we_i && (a == A_TX || a == A_TXL)) begin
          if (tx_n != DEPTH) begin
            m_ack   = 1'b1;
            m_rdata = '0;
            push_tx = 1'b1;
            nb      = '{last: (a == A_TXL), data: bus.wbs_dat_i};
          end
        end else if (!bus.wbs_we_i && a == A_RX) begin
          if (rx_n != 0) begin
            m_ack   = 1'b1;
            m_rdata = m_rx[0].data;
            pop_rx  = 1'b1;
          end
        end else begin
          m_ack   = 1'b1;
          m_rdata = (!bus.wbs_we_i && a == A_ST) ? m_status() : '0;
        end
      end
      if (do_tx_pop)  void'(m_tx.pop_front());
      if (push_tx)    m_tx.push_back(nb);
      if (pop_rx)     void'(m_rx.pop_front());
      if (do_rx_push) m_rx.push_back('{last: bus.ss_tlast, data: bus.ss_tdata});
    end
    model_on = 1'b1;
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (model_on) begin
      check("wb_ready",  DW'(bus.wb_ready),  DW'(m_ack));
      check("wbs_dat_o", bus.wbs_dat_o,      m_rdata);
      check("sm_tvalid", DW'(bus.sm_tvalid), DW'(m_tx.size() != 0));
      if (m_tx.size() != 0) begin
        check("sm_tdata", bus.sm_tdata,      m_tx[0].data);
        check("sm_tlast", DW'(bus.sm_tlast), DW'(m_tx[0].last));
      end
      check("ss_tready", DW'(bus.ss_tready), DW'(!rst && m_rx.size() != DEPTH));
    end
  end

  // Log of beats the stream consumer takes (handshake completes next edge)
  always @(negedge clk) begin
    if (!rst && bus.sm_tvalid && bus.sm_tready)
      sent.push_back('{last: bus.sm_tlast, data: bus.sm_tdata});
  end

  // ---------------- stimulus helpers ----------------
  // Called just after a rising edge; returns after the ack edge + 1.
  task automatic wb_access(input logic [31:0] adr, input logic we, input logic [DW-1:0] wdata,
                           output logic [DW-1:0] rdata, output int edges);
    bus.wbs_adr_i = adr;
    bus.wbs_we_i  = we;
    bus.wbs_dat_i = wdata;
    bus.wb_valid  = 1'b1;
    edges = 0;
    while (edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (bus.wb_ready) break;
    end
    if (!bus.wb_ready) check("ack_timeout", DW'(bus.wb_ready), DW'(1));
    rdata = bus.wbs_dat_o;
    @(posedge clk);
    #1;
    bus.wb_valid = 1'b0;
    bus.wbs_we_i = 1'b0;
  endtask

  task automatic wb_wr(input logic [31:0] adr, input logic [DW-1:0] d, input int exp_edges, input string nm);
    logic [DW-1:0] r;
    int            e;
    wb_access(adr, 1'b1, d, r, e);
    check({nm, "_ack_edges"}, DW'(e), DW'(exp_edges));
    check({nm, "_rdata"}, r, '0);
  endtask

  task automatic wb_rd(input logic [31:0] adr, input logic [DW-1:0] exp, input int exp_edges, input string nm);
    logic [DW-1:0] r;
    int            e;
    wb_access(adr, 1'b0, '0, r, e);
    check({nm, "_ack_edges"}, DW'(e), DW'(exp_edges));
    check({nm, "_rdata"}, r, exp);
  endtask

  // Present one RX beat until accepted; called just after a rising edge.
  task automatic ss_send(input logic [DW-1:0] d, input logic last);
    bus.ss_tvalid = 1'b1;
    bus.ss_tdata  = d;
    bus.ss_tlast  = last;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.ss_tready) break;
    end
    check("ss_accept", DW'(bus.ss_tready), DW'(1));
    @(posedge clk);
    #1;
    bus.ss_tvalid = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.wbs_adr_i = '0;
    bus.wb_valid  = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_dat_i = '0;
    bus.sm_tready = 1'b0;
    bus.ss_tvalid = 1'b0;
    bus.ss_tdata  = '0;
    bus.ss_tlast  = 1'b0;

    // Reset state
    @(posedge clk);
    @(negedge clk);
    check("rst_wb_ready",  DW'(bus.wb_ready),  '0);
    check("rst_wbs_dat_o", bus.wbs_dat_o,      '0);
    check("rst_sm_tvalid", DW'(bus.sm_tvalid), '0);
    check("rst_sm_tdata",  bus.sm_tdata,       '0);
    check("rst_sm_tlast",  DW'(bus.sm_tlast),  '0);
    check("rst_ss_tready", DW'(bus.ss_tready), '0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle_ss_tready", DW'(bus.ss_tready), DW'(1));
    check("idle_sm_tvalid", DW'(bus.sm_tvalid), '0);
    @(posedge clk);
    #1;
    wb_rd(A_ST, 32'h0000_0002, 1, "status_idle");

    // Fill TX with the stream stalled, then a 5th write waits for a pop
    wb_wr(A_TX, 32'd1, 1, "tx1");
    wb_wr(A_TX, 32'd2, 1, "tx2");
    wb_wr(A_TX, 32'd3, 1, "tx3");
    wb_wr(A_TX, 32'd4, 1, "tx4");
    wb_rd(A_ST, 32'h0000_0403, 1, "status_tx_full");
    sent.delete();
    fork
      wb_wr(A_TX, 32'd5, 5, "tx5_stalled");
      begin
        repeat (3) @(posedge clk);
        #1 bus.sm_tready = 1'b1;
      end
    join
    repeat (8) @(posedge clk);
    #1 bus.sm_tready = 1'b0;
    check("tx_beats", DW'(sent.size()), DW'(5));
    for (int i = 0; i < 5; i++) begin
      if (i < sent.size()) begin
        check($sformatf("tx_beat%0d_data", i), sent[i].data, DW'(i + 1));
        check($sformatf("tx_beat%0d_last", i), DW'(sent[i].last), '0);
      end
    end

    // TX_LAST framing
    wb_wr(A_TXL, 32'd7, 1, "txl7");
    @(negedge clk);
    check("txl_tvalid", DW'(bus.sm_tvalid), DW'(1));
    check("txl_tdata",  bus.sm_tdata,       32'd7);
    check("txl_tlast",  DW'(bus.sm_tlast),  DW'(1));
    @(posedge clk);
    #1 bus.sm_tready = 1'b1;
    @(posedge clk);
    #1 bus.sm_tready = 1'b0;

    // RX path with TLAST reported in status
    ss_send(32'd10, 1'b0);
    ss_send(32'd11, 1'b1);
    wb_rd(A_ST, 32'h0002_0000, 1, "status_rx2");
    wb_rd(A_RX, 32'd10, 1, "rx10");
    wb_rd(A_ST, 32'h0001_0004, 1, "status_rx_last");
    wb_rd(A_RX, 32'd11, 1, "rx11");

    // RX read on empty FIFO waits for the stream
    fork
      wb_rd(A_RX, 32'd42, 5, "rx_empty_wait");
      begin
        repeat (3) @(posedge clk);
        #1 ss_send(32'd42, 1'b0);
      end
    join
    wb_rd(A_ST, 32'h0000_0002, 1, "status_rx_drained");

    // RX full: back-pressure, then pop and push in consecutive cycles
    ss_send(32'd20, 1'b0);
    ss_send(32'd21, 1'b0);
    ss_send(32'd22, 1'b0);
    ss_send(32'd23, 1'b0);
    @(negedge clk);
    check("rx_full_tready", DW'(bus.ss_tready), '0);
    @(posedge clk);
    #1;
    wb_rd(A_ST, 32'h0004_0000, 1, "status_rx_full");
    bus.ss_tvalid = 1'b1;
    bus.ss_tdata  = 32'd24;
    bus.ss_tlast  = 1'b0;
    fork
      wb_rd(A_RX, 32'd20, 1, "rx_full_pop");
      begin
        @(negedge clk);
        check("rx_full_before_pop", DW'(bus.ss_tready), '0);
        @(negedge clk);
        check("rx_count3_tready", DW'(bus.ss_tready), DW'(1));
        @(posedge clk);
        #1 bus.ss_tvalid = 1'b0;
      end
    join
    @(negedge clk);
    check("rx_count4_tready", DW'(bus.ss_tready), '0);
    @(posedge clk);
    #1;
    wb_rd(A_RX, 32'd21, 1, "rx21");
    wb_rd(A_RX, 32'd22, 1, "rx22");
    wb_rd(A_RX, 32'd23, 1, "rx23");
    wb_rd(A_RX, 32'd24, 1, "rx24");
    wb_rd(A_ST, 32'h0000_0002, 1, "status_after_full");

    // Unmapped and wrong-direction accesses: ack, zero data, no side effect
    wb_wr(A_TX, 32'h55, 1, "tx55");
    wb_rd(A_ST, 32'h0000_0102, 1, "status_tx1");
    wb_rd(32'h3000_0090, 32'h0, 1, "unmapped_rd");
    wb_wr(A_ST, 32'hFFFF_FFFF, 1, "status_wr");
    wb_rd(A_TX, 32'h0, 1, "tx_rd");
    wb_rd(A_TXL, 32'h0, 1, "txl_rd");
    wb_wr(A_RX, 32'd123, 1, "rx_wr");
    wb_wr(32'h3000_0100, 32'd9, 1, "unmapped_wr");
    wb_rd(A_ST, 32'h0000_0102, 1, "status_unchanged");

    // Reset during a stalled TX write
    wb_wr(A_TX, 32'h60, 1, "tx60");
    wb_wr(A_TX, 32'h61, 1, "tx61");
    wb_wr(A_TX, 32'h62, 1, "tx62");
    bus.wbs_adr_i = A_TX;
    bus.wbs_we_i  = 1'b1;
    bus.wbs_dat_i = 32'd99;
    bus.wb_valid  = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("stall_no_ack", DW'(bus.wb_ready), '0);
    end
    @(posedge clk);
    #1;
    rst           = 1'b1;
    bus.wb_valid  = 1'b0;
    bus.wbs_we_i  = 1'b0;
    @(negedge clk);
    check("rst_mid_tready", DW'(bus.ss_tready), '0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_no_ack",   DW'(bus.wb_ready),  '0);
    check("rst_mid_tx_empty", DW'(bus.sm_tvalid), '0);
    check("rst_mid_tdata",    bus.sm_tdata,       '0);
    check("rst_mid_rx_ready", DW'(bus.ss_tready), DW'(1));
    @(posedge clk);
    #1;
    wb_rd(A_ST, 32'h0000_0002, 1, "status_after_rst");

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
